// File: rtl/bsg_manycore_endpoint_credit_tracker.sv
// bsg_manycore_endpoint_credit_tracker
//
// Outstanding-request tracker for a manycore endpoint. It keeps:
//   - a credit pool of max_out_credits_p outstanding requests;
//   - a per-load-id pending scoreboard;
//   - an optional fence FSM that drains all outstanding traffic;
//   - a sticky record of the first protocol error.
//
// Ports:
//   clk_i, reset_n_i             clock, asynchronous active-low reset
//   req_v_i, req_is_load_i,      outgoing request offer; load requests carry an id
//   req_load_id_i, req_ready_o   req_ready_o gates issue (combinational)
//   ret_v_i, ret_is_load_i,      return packet consumed this cycle
//   ret_load_id_i                id carried by a load response
//   fence_req_i                  start a drain of all outstanding traffic
//   fence_busy_o, fence_done_o   fence in progress / one-cycle completion pulse
//   out_credits_o                available credits
//   id_pending_o                 scoreboard, one bit per load id
//   err_o, err_code_o            sticky first error (01 overflow, 10 unexpected id, 11 duplicate id)
module bsg_manycore_endpoint_credit_tracker #(
  parameter int max_out_credits_p       = 16,
  parameter int load_id_width_p         = 5,
  parameter int fence_en_p              = 1,
  parameter int credit_counter_width_lp = $clog2(max_out_credits_p + 1),
  parameter int num_ids_lp              = 1 << load_id_width_p
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               req_v_i,
  input  logic                               req_is_load_i,
  input  logic [load_id_width_p-1:0]         req_load_id_i,
  output logic                               req_ready_o,
  input  logic                               ret_v_i,
  input  logic                               ret_is_load_i,
  input  logic [load_id_width_p-1:0]         ret_load_id_i,
  input  logic                               fence_req_i,
  output logic                               fence_busy_o,
  output logic                               fence_done_o,
  output logic [credit_counter_width_lp-1:0] out_credits_o,
  output logic [num_ids_lp-1:0]              id_pending_o,
  output logic                               err_o,
  output logic [1:0]                         err_code_o
);

  localparam logic [credit_counter_width_lp-1:0] max_credits_lp =
    credit_counter_width_lp'(max_out_credits_p);
  localparam logic [credit_counter_width_lp-1:0] one_credit_lp =
    credit_counter_width_lp'(1);
  localparam logic [credit_counter_width_lp-1:0] zero_credit_lp =
    credit_counter_width_lp'(0);

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_drain = 2'd1,
    st_done  = 2'd2
  } state_e;

  state_e                               state_q, state_d;
  logic [credit_counter_width_lp-1:0]   credits_q, credits_d;
  logic [num_ids_lp-1:0]                id_pending_q, id_pending_d;
  logic                                 err_q, err_d;
  logic [1:0]                           err_code_q, err_code_d;

  logic fence_busy;
  logic fence_done;
  logic issue;
  logic overflow_err;
  logic unexp_id_err;
  logic dup_id_err;

  // Request gating and protocol-error detection, all from registered state.
  always_comb begin
    req_ready_o  = (credits_q != zero_credit_lp) & ~fence_busy
                 & ~(req_is_load_i & id_pending_q[req_load_id_i]);
    issue        = req_v_i & req_ready_o;
    overflow_err = ret_v_i & (credits_q == max_credits_lp) & ~issue;
    unexp_id_err = ret_v_i & ret_is_load_i & ~id_pending_q[ret_load_id_i];
    dup_id_err   = req_v_i & req_is_load_i & id_pending_q[req_load_id_i]
                 & (credits_q != zero_credit_lp) & ~fence_busy;
  end

  // Credit pool: issue takes one, return gives one, both cancel; saturate at max.
  always_comb begin
    credits_d = credits_q;
    if (issue && !ret_v_i) begin
      credits_d = credits_q - one_credit_lp;
    end else if (!issue && ret_v_i) begin
      if (credits_q == max_credits_lp) begin
        credits_d = credits_q;
      end else begin
        credits_d = credits_q + one_credit_lp;
      end
    end else begin
      credits_d = credits_q;
    end
  end

  // Scoreboard update; the clear is applied last so it wins on a same-id collision.
  always_comb begin
    id_pending_d = id_pending_q;
    if (issue && req_is_load_i) begin
      id_pending_d[req_load_id_i] = 1'b1;
    end else begin
      id_pending_d = id_pending_q;
    end
    if (ret_v_i && ret_is_load_i) begin
      id_pending_d[ret_load_id_i] = 1'b0;
    end else begin
      id_pending_d = id_pending_d;
    end
  end

  // Sticky error: only the first error is recorded, highest-priority cause wins.
  always_comb begin
    err_d      = err_q;
    err_code_d = err_code_q;
    if (!err_q) begin
      if (overflow_err) begin
        err_d      = 1'b1;
        err_code_d = 2'b01;
      end else if (unexp_id_err) begin
        err_d      = 1'b1;
        err_code_d = 2'b10;
      end else if (dup_id_err) begin
        err_d      = 1'b1;
        err_code_d = 2'b11;
      end else begin
        err_d      = 1'b0;
        err_code_d = 2'b00;
      end
    end else begin
      err_d      = err_q;
      err_code_d = err_code_q;
    end
  end

  // Fence next-state: drain completes once every credit and id has come home.
  always_comb begin
    state_d = state_q;
    if (fence_en_p == 0) begin
      state_d = st_idle;
    end else begin
      case (state_q)
        st_idle: begin
          if (fence_req_i) begin
            state_d = st_drain;
          end else begin
            state_d = st_idle;
          end
        end
        st_drain: begin
          if ((credits_q == max_credits_lp) && (id_pending_q == '0)) begin
            state_d = st_done;
          end else begin
            state_d = st_drain;
          end
        end
        st_done: state_d = st_idle;
        default: state_d = st_idle;
      endcase
    end
  end

  // Fence outputs decoded from the state register.
  always_comb begin
    case (state_q)
      st_idle: begin
        fence_busy = 1'b0;
        fence_done = 1'b0;
      end
      st_drain: begin
        fence_busy = 1'b1;
        fence_done = 1'b0;
      end
      st_done: begin
        fence_busy = 1'b1;
        fence_done = 1'b1;
      end
      default: begin
        fence_busy = 1'b0;
        fence_done = 1'b0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= st_idle;
      credits_q    <= max_credits_lp;
      id_pending_q <= '0;
      err_q        <= 1'b0;
      err_code_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      id_pending_q <= id_pending_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign fence_busy_o  = fence_busy;
  assign fence_done_o  = fence_done;
  assign out_credits_o = credits_q;
  assign id_pending_o  = id_pending_q;
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;

endmodule

// File: tb/tb_bsg_manycore_endpoint_credit_tracker.sv
module tb_bsg_manycore_endpoint_credit_tracker;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        req_v_i, req_is_load_i;
  logic [4:0]  req_load_id_i;
  logic        req_ready_o;
  logic        ret_v_i, ret_is_load_i;
  logic [4:0]  ret_load_id_i;
  logic        fence_req_i;
  logic        fence_busy_o, fence_done_o;
  logic [4:0]  out_credits_o;
  logic [31:0] id_pending_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  int checks = 0;
  int errors = 0;

  bsg_manycore_endpoint_credit_tracker dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_v_i(req_v_i), .req_is_load_i(req_is_load_i), .req_load_id_i(req_load_id_i),
    .req_ready_o(req_ready_o),
    .ret_v_i(ret_v_i), .ret_is_load_i(ret_is_load_i), .ret_load_id_i(ret_load_id_i),
    .fence_req_i(fence_req_i), .fence_busy_o(fence_busy_o), .fence_done_o(fence_done_o),
    .out_credits_o(out_credits_o), .id_pending_o(id_pending_o),
    .err_o(err_o), .err_code_o(err_code_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one active edge, then settle just after it
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    req_v_i = 1'b0; req_is_load_i = 1'b0; req_load_id_i = 5'd0;
    ret_v_i = 1'b0; ret_is_load_i = 1'b0; ret_load_id_i = 5'd0;
    fence_req_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk_i);
    reset_n_i = 1'b0;
    #3;
    reset_n_i = 1'b1;
    tick();
  endtask

  initial begin
    idle_inputs();
    reset_n_i = 1'b0;
    #12;
    // reset state
    check_eq("rst_credits", 64'(out_credits_o), 64'd16);
    check_eq("rst_pending", 64'(id_pending_o), 64'd0);
    check_eq("rst_busy", 64'(fence_busy_o), 64'd0);
    check_eq("rst_done", 64'(fence_done_o), 64'd0);
    check_eq("rst_err", 64'(err_o), 64'd0);
    check_eq("rst_code", 64'(err_code_o), 64'd0);
    reset_n_i = 1'b1;
    tick();

    // 1: exhaust the credit pool, then return one
    req_v_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1 check_eq("t1_ready", 64'(req_ready_o), 64'd1);
      tick();
      check_eq("t1_credits", 64'(out_credits_o), 64'(15 - i));
    end
    #1 check_eq("t1_ready_at_0", 64'(req_ready_o), 64'd0);
    tick();
    check_eq("t1_no_wrap", 64'(out_credits_o), 64'd0);
    req_v_i = 1'b0;
    ret_v_i = 1'b1;
    #1 check_eq("t1_no_bypass", 64'(req_ready_o), 64'd0);
    tick();
    ret_v_i = 1'b0;
    check_eq("t1_one_back", 64'(out_credits_o), 64'd1);
    check_eq("t1_ready_back", 64'(req_ready_o), 64'd1);
    check_eq("t1_no_err", 64'(err_o), 64'd0);

    // 2: duplicate load id issue
    do_reset();
    req_v_i = 1'b1; req_is_load_i = 1'b1; req_load_id_i = 5'd3;
    tick();
    check_eq("t2_pending3", 64'(id_pending_o), 64'h8);
    check_eq("t2_credits", 64'(out_credits_o), 64'd15);
    #1 check_eq("t2_dup_blocked", 64'(req_ready_o), 64'd0);
    tick();
    req_v_i = 1'b0; req_is_load_i = 1'b0;
    check_eq("t2_credits_hold", 64'(out_credits_o), 64'd15);
    check_eq("t2_err", 64'(err_o), 64'd1);
    check_eq("t2_code", 64'(err_code_o), 64'd3);
    ret_v_i = 1'b1; ret_is_load_i = 1'b1; ret_load_id_i = 5'd3;
    tick();
    ret_v_i = 1'b0; ret_is_load_i = 1'b0;
    check_eq("t2_cleared", 64'(id_pending_o), 64'd0);
    check_eq("t2_credits_full", 64'(out_credits_o), 64'd16);
    check_eq("t2_code_sticky", 64'(err_code_o), 64'd3);

    // 3: simultaneous issue and return at 8 credits
    do_reset();
    req_v_i = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check_eq("t3_at8", 64'(out_credits_o), 64'd8);
    ret_v_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("t3_hold8", 64'(out_credits_o), 64'd8);
    end
    req_v_i = 1'b0; ret_v_i = 1'b0;
    check_eq("t3_no_err", 64'(err_o), 64'd0);

    // 4: fence with two loads outstanding
    do_reset();
    req_v_i = 1'b1; req_is_load_i = 1'b1; req_load_id_i = 5'd1;
    tick();
    req_load_id_i = 5'd2;
    tick();
    req_is_load_i = 1'b0; req_load_id_i = 5'd0;
    req_v_i = 1'b0;
    check_eq("t4_pending", 64'(id_pending_o), 64'h6);
    check_eq("t4_credits", 64'(out_credits_o), 64'd14);
    fence_req_i = 1'b1;
    tick();                                   // edge 0: IDLE -> DRAIN
    fence_req_i = 1'b0;
    req_v_i = 1'b1;                           // offered but must not issue
    check_eq("t4_busy", 64'(fence_busy_o), 64'd1);
    #1 check_eq("t4_ready0", 64'(req_ready_o), 64'd0);
    tick(); tick();                           // edges 1, 2
    check_eq("t4_no_issue", 64'(out_credits_o), 64'd14);
    ret_v_i = 1'b1; ret_is_load_i = 1'b1; ret_load_id_i = 5'd1;
    tick();                                   // edge 3
    ret_v_i = 1'b0; ret_is_load_i = 1'b0;
    check_eq("t4_ret1", 64'(id_pending_o), 64'h4);
    tick();                                   // edge 4
    check_eq("t4_done_early", 64'(fence_done_o), 64'd0);
    ret_v_i = 1'b1; ret_is_load_i = 1'b1; ret_load_id_i = 5'd2;
    tick();                                   // edge 5
    ret_v_i = 1'b0; ret_is_load_i = 1'b0;
    check_eq("t4_drained_credits", 64'(out_credits_o), 64'd16);
    check_eq("t4_drained_ids", 64'(id_pending_o), 64'd0);
    check_eq("t4_done_not_yet", 64'(fence_done_o), 64'd0);
    tick();                                   // edge 6: DONE
    check_eq("t4_done", 64'(fence_done_o), 64'd1);
    check_eq("t4_done_busy", 64'(fence_busy_o), 64'd1);
    check_eq("t4_done_ready", 64'(req_ready_o), 64'd0);
    tick();                                   // edge 7: IDLE
    check_eq("t4_done_off", 64'(fence_done_o), 64'd0);
    check_eq("t4_idle_busy", 64'(fence_busy_o), 64'd0);
    check_eq("t4_idle_ready", 64'(req_ready_o), 64'd1);
    req_v_i = 1'b0;
    check_eq("t4_no_err", 64'(err_o), 64'd0);

    // 4b: fence with nothing outstanding
    do_reset();
    fence_req_i = 1'b1;
    tick();
    fence_req_i = 1'b0;
    check_eq("t4b_busy", 64'(fence_busy_o), 64'd1);
    check_eq("t4b_done0", 64'(fence_done_o), 64'd0);
    tick();
    check_eq("t4b_done1", 64'(fence_done_o), 64'd1);
    tick();
    check_eq("t4b_done_off", 64'(fence_done_o), 64'd0);
    check_eq("t4b_busy_off", 64'(fence_busy_o), 64'd0);

    // 5: overflow, then unexpected id keeps first code
    do_reset();
    ret_v_i = 1'b1;
    tick();
    ret_v_i = 1'b0;
    check_eq("t5_sat", 64'(out_credits_o), 64'd16);
    check_eq("t5_err", 64'(err_o), 64'd1);
    check_eq("t5_code", 64'(err_code_o), 64'd1);
    req_v_i = 1'b1;
    tick();
    req_v_i = 1'b0;
    ret_v_i = 1'b1; ret_is_load_i = 1'b1; ret_load_id_i = 5'd7;
    tick();
    ret_v_i = 1'b0; ret_is_load_i = 1'b0;
    check_eq("t5_code_kept", 64'(err_code_o), 64'd1);
    check_eq("t5_bit7", 64'(id_pending_o), 64'd0);

    // 5b: unexpected id alone gives code 10; overflow+unexpected gives 01
    do_reset();
    req_v_i = 1'b1;
    tick();
    req_v_i = 1'b0;
    ret_v_i = 1'b1; ret_is_load_i = 1'b1; ret_load_id_i = 5'd9;
    tick();
    ret_v_i = 1'b0; ret_is_load_i = 1'b0;
    check_eq("t5b_code10", 64'(err_code_o), 64'd2);
    check_eq("t5b_credits", 64'(out_credits_o), 64'd16);
    do_reset();
    ret_v_i = 1'b1; ret_is_load_i = 1'b1; ret_load_id_i = 5'd5;
    tick();
    ret_v_i = 1'b0; ret_is_load_i = 1'b0;
    check_eq("t5b_prio01", 64'(err_code_o), 64'd1);

    // 6: reset mid-drain
    do_reset();
    req_v_i = 1'b1; req_is_load_i = 1'b1; req_load_id_i = 5'd4;
    tick();
    req_is_load_i = 1'b0; req_load_id_i = 5'd0;
    for (int i = 0; i < 3; i++) tick();
    req_v_i = 1'b0;
    check_eq("t6_credits12", 64'(out_credits_o), 64'd12);
    fence_req_i = 1'b1;
    tick();
    fence_req_i = 1'b0;
    tick();
    check_eq("t6_busy", 64'(fence_busy_o), 64'd1);
    #2 reset_n_i = 1'b0;
    #1;
    check_eq("t6_rst_credits", 64'(out_credits_o), 64'd16);
    check_eq("t6_rst_busy", 64'(fence_busy_o), 64'd0);
    check_eq("t6_rst_pending", 64'(id_pending_o), 64'd0);
    check_eq("t6_rst_done", 64'(fence_done_o), 64'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t6_no_done", 64'(fence_done_o), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
